// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        REDIR = 2'd3
    } fetch_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_REDIR = 2'd3;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue; pointers carry an extra wrap bit to tell full from empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             res,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

    // At full, a same-cycle pop frees the head slot the push lands in.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (res || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!res && !flush && do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, pipelined fixed-latency reads, credit-limited queue, redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       PC_STEP    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       MEM_LAT    = 1,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              res,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic [1:0]        state_out
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned QW = ADDR_W + DATA_W;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              epoch;

    // In-flight tracker: stage MEM_LAT-1 lines up with the returning mem_rdata.
    logic [MEM_LAT-1:0] tr_valid;
    logic [MEM_LAT-1:0] tr_epoch;
    logic [ADDR_W-1:0]  tr_pc [MEM_LAT];

    logic              issue;
    logic              credit_ok;
    int unsigned       inflight_cnt;
    logic              resp_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;
    logic [QW-1:0]     q_rdata;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            inflight_cnt = inflight_cnt + 32'(tr_valid[i]);
        end
    end

    // Counts as of cycle start only, so the queue can never overflow.
    assign credit_ok = (inflight_cnt + 32'(q_count)) < FIFO_DEPTH;
    assign issue     = (state == FETCH) && credit_ok && !redirect_valid;

    assign resp_push = tr_valid[MEM_LAT-1] && (tr_epoch[MEM_LAT-1] == epoch) && !redirect_valid
                       && (!q_full || q_pop);
    assign q_pop     = inst_valid && inst_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .res   (res),
        .push  (resp_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .wdata ({tr_pc[MEM_LAT-1], mem_rdata}),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (redirect_valid)  state_nxt = REDIR;
                else if (!credit_ok) state_nxt = FULL;
            end
            FULL: begin
                if (redirect_valid) state_nxt = REDIR;
                else if (credit_ok) state_nxt = FETCH;
            end
            REDIR: state_nxt = redirect_valid ? REDIR : FETCH;
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid) pc_nxt = redirect_pc;
        else if (issue)     pc_nxt = pc + ADDR_W'(PC_STEP);
    end

    always_ff @(posedge clock) begin
        if (res) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            epoch    <= 1'b0;
            tr_valid <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (redirect_valid) epoch <= ~epoch;
            for (int i = int'(MEM_LAT) - 1; i > 0; i--) tr_valid[i] <= tr_valid[i-1];
            tr_valid[0] <= issue;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
            tr_pc[i]    <= tr_pc[i-1];
            tr_epoch[i] <= tr_epoch[i-1];
        end
        tr_pc[0]    <= pc;
        tr_epoch[0] <= epoch;
    end

    assign mem_addr   = pc;
    assign mem_rd     = issue;
    assign inst_valid = !q_empty;
    assign inst_data  = q_empty ? '0 : q_rdata[DATA_W-1:0];
    assign inst_pc    = q_empty ? '0 : q_rdata[QW-1:DATA_W];
    assign pc_out     = pc;
    assign state_out  = state;

endmodule
